// File: rtl/fp_add_sequencer.sv
// Sequential floating-point adder. One operand pair at a time passes through
// ALIGN, ADD, NORM and ROUND (one cycle each) and is held in DONE until accepted.
module fp_add_sequencer #(
  parameter int unsigned EXPBITS  = 8,
  parameter int unsigned FRACBITS = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXPBITS+FRACBITS:0] a,
  input  logic [EXPBITS+FRACBITS:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXPBITS+FRACBITS:0] sum,
  output logic [3:0]                flags
);

  localparam int unsigned Width = 1 + EXPBITS + FRACBITS;
  localparam int unsigned SigW  = FRACBITS + 1;  // significand with hidden bit
  localparam int unsigned ExtW  = SigW + 3;      // plus guard, round, sticky
  localparam int unsigned SumW  = ExtW + 1;      // plus carry-out
  localparam int unsigned ExpW  = EXPBITS + 2;   // two's-complement working exponent
  localparam int unsigned LzcW  = $clog2(SumW) + 1;

  localparam logic [Width-1:0] QuietNan =
      {1'b0, {EXPBITS{1'b1}}, 1'b1, {(FRACBITS - 1){1'b0}}};
  localparam logic [ExpW-1:0] ExpAllOnes = {2'b00, {EXPBITS{1'b1}}};

  typedef enum logic [2:0] {
    StIdle, StAlign, StAdd, StNorm, StRound, StDone
  } state_e;

  state_e state_q, state_d;

  logic [Width-1:0] a_q, b_q;
  logic             sign_q, sub_q, special_q, zero_q;
  logic [Width-1:0] spec_q;
  logic [3:0]       spec_flags_q;
  logic [ExpW-1:0]  exp_q;
  logic [ExtW-1:0]  big_q, small_q, norm_q;
  logic [SumW-1:0]  add_q;
  logic [Width-1:0] sum_q;
  logic [3:0]       flags_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign sum   = sum_q;
  assign flags = flags_q;

  // ---------------------------------------------------------------- ALIGN
  logic                sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big;
  logic [EXPBITS-1:0]  ea, eb, big_exp, small_exp, shamt;
  logic [FRACBITS-1:0] fa, fb;
  logic [Width-2:0]    mag_a, mag_b, big_mag, small_mag;
  logic [SigW-1:0]     big_sig, small_sig;
  logic [ExtW-1:0]     small_ext, small_shift;
  logic                small_sticky, al_special, al_sign;
  logic [Width-1:0]    al_spec;
  logic [3:0]          al_spec_flags;

  always_comb begin
    sa = a_q[Width-1];
    sb = b_q[Width-1];
    ea = a_q[Width-2:FRACBITS];
    eb = b_q[Width-2:FRACBITS];
    fa = a_q[FRACBITS-1:0];
    fb = b_q[FRACBITS-1:0];
    nan_a  = (&ea) && (|fa);
    nan_b  = (&eb) && (|fb);
    inf_a  = (&ea) && !(|fa);
    inf_b  = (&eb) && !(|fb);
    // Denormals flush to zero: a zero exponent means zero magnitude.
    zero_a = (ea == '0);
    zero_b = (eb == '0);
    mag_a  = zero_a ? '0 : a_q[Width-2:0];
    mag_b  = zero_b ? '0 : b_q[Width-2:0];

    a_big     = (mag_a >= mag_b);
    big_mag   = a_big ? mag_a : mag_b;
    small_mag = a_big ? mag_b : mag_a;
    al_sign   = a_big ? sa : sb;
    big_exp   = big_mag[Width-2:FRACBITS];
    small_exp = small_mag[Width-2:FRACBITS];
    big_sig   = {|big_exp, big_mag[FRACBITS-1:0]};
    small_sig = {|small_exp, small_mag[FRACBITS-1:0]};
    shamt     = big_exp - small_exp;

    // Everything shifted past the extension collapses into the sticky bit.
    small_ext    = {small_sig, 3'b000};
    small_sticky = |(small_ext & ~({ExtW{1'b1}} << shamt));
    small_shift  = (small_ext >> shamt) | ExtW'(small_sticky);

    al_special    = 1'b1;
    al_spec       = '0;
    al_spec_flags = 4'b0000;
    if (nan_a || nan_b) begin
      al_spec = QuietNan;
    end else if (inf_a && inf_b && (sa != sb)) begin
      al_spec       = QuietNan;
      al_spec_flags = 4'b1000;
    end else if (inf_a) begin
      al_spec = a_q;
    end else if (inf_b) begin
      al_spec = b_q;
    end else if (zero_a && zero_b) begin
      al_spec = {sa & sb, {(Width - 1){1'b0}}};
    end else begin
      al_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------- NORM
  logic [LzcW-1:0] lzc;
  logic            lz_found;
  logic [ExtW-1:0] nm_norm;
  logic [ExpW-1:0] nm_exp;

  always_comb begin
    lzc      = LzcW'(ExtW);
    lz_found = 1'b0;
    for (int i = int'(ExtW) - 1; i >= 0; i--) begin
      if (!lz_found && add_q[i]) begin
        lz_found = 1'b1;
        lzc      = LzcW'(int'(ExtW) - 1 - i);
      end
    end
    if (add_q[SumW-1]) begin
      nm_norm = {add_q[SumW-1:2], add_q[1] | add_q[0]};
      nm_exp  = exp_q + 1'b1;
    end else begin
      nm_norm = add_q[ExtW-1:0] << lzc;
      nm_exp  = exp_q - ExpW'(lzc);
    end
  end

  // ---------------------------------------------------------------- ROUND
  logic [SigW-1:0]  rd_mant;
  logic [SigW:0]    rd_rnd;
  logic             rd_g, rd_r, rd_s, rd_up, rd_inexact, rd_ovf, rd_unf;
  logic [ExpW-1:0]  rd_exp;
  logic [Width-1:0] rd_sum;
  logic [3:0]       rd_flags;

  always_comb begin
    rd_mant    = norm_q[ExtW-1:3];
    rd_g       = norm_q[2];
    rd_r       = norm_q[1];
    rd_s       = norm_q[0];
    rd_up      = rd_g & (rd_r | rd_s | rd_mant[0]);
    rd_rnd     = {1'b0, rd_mant} + {{SigW{1'b0}}, rd_up};
    rd_exp     = rd_rnd[SigW] ? exp_q + 1'b1 : exp_q;
    rd_inexact = rd_g | rd_r | rd_s;
    rd_ovf     = !rd_exp[ExpW-1] && (rd_exp >= ExpAllOnes);
    rd_unf     = rd_exp[ExpW-1] || (rd_exp == '0);

    if (special_q) begin
      rd_sum   = spec_q;
      rd_flags = spec_flags_q;
    end else if (zero_q) begin
      rd_sum   = '0;
      rd_flags = 4'b0000;
    end else if (rd_ovf) begin
      rd_sum   = {sign_q, {EXPBITS{1'b1}}, {FRACBITS{1'b0}}};
      rd_flags = 4'b0101;
    end else if (rd_unf) begin
      rd_sum   = {sign_q, {(Width - 1){1'b0}}};
      rd_flags = 4'b0011;
    end else begin
      // A rounding carry leaves the fraction bits zero, so no extra shift is needed.
      rd_sum   = {sign_q, rd_exp[EXPBITS-1:0], rd_rnd[FRACBITS-1:0]};
      rd_flags = {3'b000, rd_inexact};
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= 1'b0;
      sub_q        <= 1'b0;
      special_q    <= 1'b0;
      zero_q       <= 1'b0;
      spec_q       <= '0;
      spec_flags_q <= '0;
      exp_q        <= '0;
      big_q        <= '0;
      small_q      <= '0;
      add_q        <= '0;
      norm_q       <= '0;
      sum_q        <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        StAlign: begin
          sign_q       <= al_sign;
          sub_q        <= sa ^ sb;
          exp_q        <= {2'b00, big_exp};
          big_q        <= {big_sig, 3'b000};
          small_q      <= small_shift;
          special_q    <= al_special;
          spec_q       <= al_spec;
          spec_flags_q <= al_spec_flags;
        end
        StAdd: begin
          add_q <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                         : ({1'b0, big_q} + {1'b0, small_q});
        end
        StNorm: begin
          norm_q <= nm_norm;
          exp_q  <= nm_exp;
          zero_q <= (add_q == '0);
        end
        StRound: begin
          sum_q   <= rd_sum;
          flags_q <= rd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer: a driver pushes reference results, an
// independent monitor pops and compares whenever out_valid is presented.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic [3:0]  flags;

  fp_add_sequencer #(.EXPBITS(8), .FRACBITS(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [3:0]  flags;
    logic [31:0] acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Exact reference: both magnitudes as wide integers on a common scale, then RNE.
  function automatic logic [35:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    int           ex, ey, emin, p, sh, e;
    logic         sx, sy, s, inexact, up, zx, zy;
    logic [22:0]  fx, fy;
    logic [287:0] mx, my, mag, rem, half;
    logic [24:0]  mant;
    sx = x[31];
    sy = y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) return {4'b0000, 32'h7FC00000};
    if (ex == 255 && ey == 255 && sx != sy) return {4'b1000, 32'h7FC00000};
    if (ex == 255) return {4'b0000, sx, 31'h7F800000};
    if (ey == 255) return {4'b0000, sy, 31'h7F800000};
    zx = (ex == 0);
    zy = (ey == 0);
    if (zx && zy) return {4'b0000, sx & sy, 31'h0};
    emin = zx ? ey : (zy ? ex : ((ex < ey) ? ex : ey));
    mx = zx ? '0 : ({264'h0, 1'b1, fx} << (ex - emin));
    my = zy ? '0 : ({264'h0, 1'b1, fy} << (ey - emin));
    if (sx == sy) begin
      mag = mx + my;
      s   = sx;
    end else if (mx >= my) begin
      mag = mx - my;
      s   = sx;
    end else begin
      mag = my - mx;
      s   = sy;
    end
    if (mag == '0) return {4'b0000, 32'h0};
    p = 0;
    for (int i = 0; i < 288; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (p > 23) begin
      sh      = p - 23;
      mant    = 25'(mag >> sh);
      rem     = mag & ((288'h1 << sh) - 288'h1);
      half    = 288'h1 << (sh - 1);
      inexact = (rem != '0);
      up      = (rem > half) || (rem == half && mant[0]);
    end else begin
      mant    = 25'(mag << (23 - p));
      inexact = 1'b0;
      up      = 1'b0;
    end
    mant = mant + 25'(up);
    if (mant[24]) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 31'h7F800000};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, inexact, s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 15))
      0:       begin e = 8'hFF; f[0] = 1'b1; end
      1:       begin e = 8'hFF; f = '0; end
      2:       begin e = 8'h00; f = '0; end
      3:       begin e = 8'h00; f[0] = 1'b1; end
      4:       e = 8'(253 + $urandom_range(0, 1));
      5:       e = 8'($urandom_range(1, 3));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] esum, input logic [3:0] eflags, input bit push);
    exp_t it;
    int   n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'(1));
      return;
    end
    a        = x;
    b        = y;
    in_valid = 1'b1;
    if (push) begin
      it.a     = x;
      it.b     = y;
      it.sum   = esum;
      it.flags = eflags;
      it.acc   = 32'(cyc + 1);
      exp_q.push_back(it);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic issue_ref(input logic [31:0] x, input logic [31:0] y);
    logic [35:0] r;
    r = ref_add(x, y);
    issue(x, y, r[31:0], r[35:32], 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_sum"}, 64'(sum), 64'(0));
    check({tag, "_flags"}, 64'(flags), 64'(0));
  endtask

  // Consumer back-pressure.
  initial begin
    forever begin
      @(negedge clk);
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per presented result and keeps checking while held.
  initial begin
    exp_t cur;
    bit   active = 1'b0;
    bit   orphan = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'(out_valid), 64'(0));
            orphan = 1'b1;
          end else begin
            cur    = exp_q.pop_front();
            orphan = 1'b0;
            check($sformatf("latency(%h+%h)", cur.a, cur.b), 64'(cyc - int'(cur.acc)), 64'(4));
          end
          active = 1'b1;
        end
        if (!orphan) begin
          check($sformatf("sum(%h+%h)", cur.a, cur.b), 64'(sum), 64'(cur.sum));
          check($sformatf("flags(%h+%h)", cur.a, cur.b), 64'(flags), 64'(cur.flags));
          check("in_ready_in_done", 64'(in_ready), 64'(0));
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] dir_a   [14] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                                32'h7F7FFFFF, 32'h00000001, 32'h80000000, 32'h7F800001,
                                32'hFF800000, 32'h7F800000, 32'h40000000, 32'h00800001,
                                32'h3F800000, 32'h3F800001};
  logic [31:0] dir_b   [14] = '{32'h40000000, 32'hBF800000, 32'h33800000, 32'hFF800000,
                                32'h7F7FFFFF, 32'h80000000, 32'h80000000, 32'h3F800000,
                                32'h3F800000, 32'h7F800000, 32'hBF800000, 32'h80800000,
                                32'h33800001, 32'h33800000};
  logic [31:0] dir_sum [14] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h7FC00000,
                                32'h7F800000, 32'h00000000, 32'h80000000, 32'h7FC00000,
                                32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h00000000,
                                32'h3F800001, 32'h3F800002};
  logic [3:0]  dir_flg [14] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000,
                                4'b0101, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0011,
                                4'b0001, 4'b0001};

  initial begin
    logic [31:0] x, y;
    int          n, ye;

    #1;
    check_reset_outputs("reset_initial");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_clocked");
    reset = 1'b0;

    for (int i = 0; i < 14; i++) issue(dir_a[i], dir_b[i], dir_sum[i], dir_flg[i], 1'b1);
    wait_drain();

    for (int i = 0; i < 300; i++) begin
      x = gen_op();
      y = gen_op();
      case ($urandom_range(0, 3))
        0: begin
          ye = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
          if (ye < 1) ye = 1;
          if (ye > 254) ye = 254;
          y = {1'($urandom), 8'(ye), 23'($urandom)};
        end
        1: y = {~x[31], x[30:0] ^ 31'($urandom_range(0, 255))};
        default: ;
      endcase
      issue_ref(x, y);
    end
    wait_drain();

    // Held result in DONE; an in_valid pulse there must be ignored.
    hold = 1'b1;
    issue(32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", 64'(out_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      a        = 32'h7F800000;
      b        = 32'h3F800000;
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    wait_drain();
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1);
    wait_drain();

    // Reset while the operation sits in ADD.
    issue(32'h3F800000, 32'h40000000, 32'h0, 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_in_add");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_out_valid", 64'(out_valid), 64'(0));
    end
    issue(32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
